// File: rtl/projectile_pool_pkg.sv
// Shared constants for the projectile pool.
// DIR_UP / DIR_DOWN select the travel direction of a pool. The default speed
// and vertical bounds come from the 640x480 visible screen area.
package projectile_pool_pkg;

  localparam bit DIR_UP   = 1'b0;
  localparam bit DIR_DOWN = 1'b1;

  localparam int SCREEN_H  = 480;
  localparam int DEF_Y_MIN = 0;
  localparam int DEF_Y_MAX = SCREEN_H - 1;
  localparam int DEF_SPEED = 4;

endpackage

// File: rtl/projectile_slot.sv
// One projectile slot: a live flag plus the (x, y) position.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   load             spawn into this slot; honoured only while the slot is free
//   load_x, load_y   spawn position
//   hit              collision pulse; clears a live slot and keeps its position
//   frame            per-frame pulse; a live slot moves or retires
//   active, x, y     registered slot state
//   active_nxt       next-cycle live flag, used by the pool to keep live_count registered
// Priority per slot: rst > hit > frame move/retire > load.
module projectile_slot
  import projectile_pool_pkg::*;
#(
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter bit DIRECTION = DIR_UP,
  parameter int SPEED     = DEF_SPEED,
  parameter int Y_MIN     = DEF_Y_MIN,
  parameter int Y_MAX     = DEF_Y_MAX
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  logic           hit,
  input  logic           frame,
  output logic           active,
  output logic           active_nxt,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  // Bounds are compared one bit wider than y so neither y+SPEED nor the
  // bound itself can wrap.
  localparam logic [Y_W:0]   SPD_W  = (Y_W+1)'(SPEED);
  localparam logic [Y_W:0]   LIM_UP = (Y_W+1)'(Y_MIN + SPEED);
  localparam logic [Y_W:0]   LIM_DN = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0] SPD_N  = Y_W'(SPEED);

  logic           active_q, active_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W:0]   y_ext;
  logic [Y_W:0]   y_inc;
  logic [Y_W-1:0] y_step;
  logic           retire;

  always_comb begin
    y_ext  = {1'b0, y_q};
    y_inc  = y_ext + SPD_W;
    if (DIRECTION == DIR_DOWN) begin
      retire = (y_inc > LIM_DN);
      y_step = y_q + SPD_N;
    end else begin
      retire = (y_ext < LIM_UP);
      y_step = y_q - SPD_N;
    end
  end

  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    if (active_q && hit) begin
      active_d = 1'b0;
    end else if (active_q && frame) begin
      if (retire) active_d = 1'b0;
      else        y_d      = y_step;
    end else if (!active_q && load) begin
      active_d = 1'b1;
      x_d      = load_x;
      y_d      = load_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign active     = active_q;
  assign active_nxt = active_d;
  assign x          = x_q;
  assign y          = y_q;

endmodule

// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS vertical projectiles (lasers going up or bombs going down).
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   frame                     one-cycle pulse per video frame
//   spawn_valid/spawn_ready   spawn handshake; ready depends only on registers
//   spawn_x, spawn_y          spawn position (caller keeps y within bounds)
//   hit                       per-slot collision pulses
//   active                    per-slot live flags
//   pos_x, pos_y              flat position buses, slot i at [i*W +: W]
//   live_count                registered popcount of active
// Spawns go to the lowest-index free slot. After an accepted spawn, COOLDOWN
// frame pulses must pass before the next spawn is accepted.
module projectile_pool
  import projectile_pool_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int SPEED     = DEF_SPEED,
  parameter bit DIRECTION = DIR_UP,
  parameter int Y_MIN     = DEF_Y_MIN,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int COOLDOWN  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame,
  input  logic                             spawn_valid,
  output logic                             spawn_ready,
  input  logic [X_W-1:0]                   spawn_x,
  input  logic [Y_W-1:0]                   spawn_y,
  input  logic [NUM_SLOTS-1:0]             hit,
  output logic [NUM_SLOTS-1:0]             active,
  output logic [NUM_SLOTS*X_W-1:0]         pos_x,
  output logic [NUM_SLOTS*Y_W-1:0]         pos_y,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   live_count
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [NUM_SLOTS-1:0] active_nxt;
  logic [NUM_SLOTS-1:0] load_vec;
  logic                 accept;
  logic                 found;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [CNT_W-1:0]     live_q, live_d;

  assign spawn_ready = (|(~active)) && (cd_q == '0);
  assign accept      = spawn_valid && spawn_ready;

  // Lowest-index free slot gets the load strobe.
  always_comb begin
    load_vec = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!active[i] && !found) begin
        load_vec[i] = accept;
        found       = 1'b1;
      end
    end
  end

  // A fresh accept reloads the cooldown even on a frame pulse.
  always_comb begin
    cd_d = cd_q;
    if (accept)                  cd_d = CD_W'(COOLDOWN);
    else if (frame && cd_q != 0) cd_d = cd_q - 1'b1;
  end

  always_comb begin
    live_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) live_d = live_d + CNT_W'(active_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cd_q   <= '0;
      live_q <= '0;
    end else begin
      cd_q   <= cd_d;
      live_q <= live_d;
    end
  end

  assign live_count = live_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    projectile_slot #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .DIRECTION(DIRECTION),
      .SPEED    (SPEED),
      .Y_MIN    (Y_MIN),
      .Y_MAX    (Y_MAX)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_vec[g]),
      .load_x    (spawn_x),
      .load_y    (spawn_y),
      .hit       (hit[g]),
      .frame     (frame),
      .active    (active[g]),
      .active_nxt(active_nxt[g]),
      .x         (pos_x[g*X_W +: X_W]),
      .y         (pos_y[g*Y_W +: Y_W])
    );
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Testbench for projectile_pool: one upward pool with no cooldown and one
// downward pool with COOLDOWN=2 share the same stimulus. Directed scenarios
// are followed by a randomized run, checked against a per-slot array model.
module tb_projectile_pool;

  logic        clk;
  logic        rst;
  logic        frame;
  logic        spawn_valid;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic [3:0]  hit;

  logic        rdy_a, rdy_b;
  logic [3:0]  act_a, act_b;
  logic [39:0] px_a, px_b, py_a, py_b;
  logic [2:0]  lc_a, lc_b;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: [pool][slot]
  int mact [2][4];
  int mx   [2][4];
  int my   [2][4];
  int mcd  [2];
  int cfg_dir [2] = '{0, 1};
  int cfg_cd  [2] = '{0, 2};

  projectile_pool #(
    .NUM_SLOTS(4), .X_W(10), .Y_W(10), .SPEED(4), .DIRECTION(1'b0),
    .Y_MIN(0), .Y_MAX(479), .COOLDOWN(0)
  ) dut_a (
    .clk(clk), .rst(rst), .frame(frame), .spawn_valid(spawn_valid),
    .spawn_ready(rdy_a), .spawn_x(spawn_x), .spawn_y(spawn_y), .hit(hit),
    .active(act_a), .pos_x(px_a), .pos_y(py_a), .live_count(lc_a)
  );

  projectile_pool #(
    .NUM_SLOTS(4), .X_W(10), .Y_W(10), .SPEED(4), .DIRECTION(1'b1),
    .Y_MIN(0), .Y_MAX(479), .COOLDOWN(2)
  ) dut_b (
    .clk(clk), .rst(rst), .frame(frame), .spawn_valid(spawn_valid),
    .spawn_ready(rdy_b), .spawn_x(spawn_x), .spawn_y(spawn_y), .hit(hit),
    .active(act_b), .pos_x(px_b), .pos_y(py_b), .live_count(lc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit model_ready(input int m);
    bit any_free = 0;
    for (int i = 0; i < 4; i++) if (mact[m][i] == 0) any_free = 1;
    return any_free && (mcd[m] == 0);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          mact[m][i] = 0; mx[m][i] = 0; my[m][i] = 0;
        end
        mcd[m] = 0;
      end else begin
        bit acc;
        int idx;
        acc = spawn_valid && model_ready(m);
        idx = -1;
        for (int i = 3; i >= 0; i--) if (mact[m][i] == 0) idx = i;
        for (int i = 0; i < 4; i++) begin
          if (mact[m][i] != 0 && hit[i]) begin
            mact[m][i] = 0;
          end else if (mact[m][i] != 0 && frame) begin
            if (cfg_dir[m] == 0) begin
              if (my[m][i] < 0 + 4) mact[m][i] = 0;
              else                  my[m][i] = my[m][i] - 4;
            end else begin
              if (my[m][i] + 4 > 479) mact[m][i] = 0;
              else                    my[m][i] = my[m][i] + 4;
            end
          end else if (mact[m][i] == 0 && acc && i == idx) begin
            mact[m][i] = 1;
            mx[m][i]   = int'(spawn_x);
            my[m][i]   = int'(spawn_y);
          end
        end
        if (acc)                        mcd[m] = cfg_cd[m];
        else if (frame && mcd[m] > 0)   mcd[m] = mcd[m] - 1;
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic [3:0]  e_act;
      logic [39:0] e_px, e_py;
      logic [2:0]  e_lc;
      logic [3:0]  o_act;
      logic [39:0] o_px, o_py;
      logic [2:0]  o_lc;
      logic        o_rdy;
      string       p;
      e_act = '0; e_px = '0; e_py = '0; e_lc = '0;
      for (int i = 0; i < 4; i++) begin
        e_act[i]        = (mact[m][i] != 0);
        e_px[i*10 +: 10] = 10'(mx[m][i]);
        e_py[i*10 +: 10] = 10'(my[m][i]);
        if (mact[m][i] != 0) e_lc = e_lc + 3'd1;
      end
      if (m == 0) begin
        o_act = act_a; o_px = px_a; o_py = py_a; o_lc = lc_a; o_rdy = rdy_a; p = "a";
      end else begin
        o_act = act_b; o_px = px_b; o_py = py_b; o_lc = lc_b; o_rdy = rdy_b; p = "b";
      end
      chk({p, "_active"}, 64'(o_act), 64'(e_act));
      chk({p, "_pos_x"},  64'(o_px),  64'(e_px));
      chk({p, "_pos_y"},  64'(o_py),  64'(e_py));
      chk({p, "_live"},   64'(o_lc),  64'(e_lc));
      chk({p, "_ready"},  64'(o_rdy), 64'(model_ready(m)));
    end
  endtask

  task automatic cyc(input bit v, input int x, input int y, input bit f,
                     input logic [3:0] h, input bit r);
    spawn_valid = v;
    spawn_x     = 10'(x);
    spawn_y     = 10'(y);
    frame       = f;
    hit         = h;
    rst         = r;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; frame = 1'b0; spawn_valid = 1'b0; spawn_x = '0; spawn_y = '0; hit = '0;
    for (int m = 0; m < 2; m++) begin
      mcd[m] = 0;
      for (int i = 0; i < 4; i++) begin mact[m][i] = 0; mx[m][i] = 0; my[m][i] = 0; end
    end
    @(negedge clk);

    // Reset, spawn, three frames upward
    cyc(0, 0, 0, 0, 4'b0, 1);
    chk("rst_ready_a", 64'(rdy_a), 64'd1);
    cyc(1, 100, 440, 0, 4'b0, 0);
    chk("spawn_act_a", 64'(act_a), 64'b0001);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 4'b0, 0);
    chk("up3_y_a", 64'(py_a[9:0]), 64'd428);
    chk("up3_live_a", 64'(lc_a), 64'd1);

    // Fill all slots back to back with no cooldown
    cyc(0, 0, 0, 0, 4'b0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 10 * k + 5, 200, 0, 4'b0, 0);
    chk("fill_live_a", 64'(lc_a), 64'd4);
    chk("fill_ready_a", 64'(rdy_a), 64'd0);

    // Hit slot 1, then the next spawn reuses it
    cyc(0, 0, 0, 0, 4'b0010, 0);
    chk("hit1_act_a", 64'(act_a), 64'b1101);
    cyc(1, 300, 100, 0, 4'b0, 0);
    chk("reuse_act_a", 64'(act_a), 64'b1111);
    chk("reuse_x_a", 64'(px_a[19:10]), 64'd300);

    // Downward retirement at the bottom edge
    cyc(0, 0, 0, 0, 4'b0, 1);
    cyc(1, 50, 472, 0, 4'b0, 0);
    cyc(0, 0, 0, 1, 4'b0, 0);
    chk("dn1_y_b", 64'(py_b[9:0]), 64'd476);
    cyc(0, 0, 0, 1, 4'b0, 0);
    chk("dn2_act_b", 64'(act_b[0]), 64'd0);
    chk("dn2_y_b", 64'(py_b[9:0]), 64'd476);

    // Cooldown of 2 frames, then spawn coincident with a frame
    cyc(0, 0, 0, 0, 4'b0, 1);
    cyc(1, 10, 100, 0, 4'b0, 0);
    cyc(1, 11, 101, 0, 4'b0, 0);
    cyc(1, 12, 102, 0, 4'b0, 0);
    chk("cd_hold_ready_b", 64'(rdy_b), 64'd0);
    cyc(1, 13, 103, 1, 4'b0, 0);
    chk("cd_one_ready_b", 64'(rdy_b), 64'd0);
    cyc(1, 14, 104, 1, 4'b0, 0);
    chk("cd_done_ready_b", 64'(rdy_b), 64'd1);
    cyc(1, 20, 300, 1, 4'b0, 0);
    chk("spawn_frame_y_b", 64'(py_b[19:10]), 64'd300);
    chk("spawn_frame_ready_b", 64'(rdy_b), 64'd0);

    // Hit and frame together, then reset mid-flight
    cyc(0, 0, 0, 0, 4'b0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 40 + k, 200, 0, 4'b0, 0);
    cyc(0, 0, 0, 1, 4'b0001, 0);
    chk("hitframe_act_a", 64'(act_a), 64'b0110);
    chk("hitframe_y0_a", 64'(py_a[9:0]), 64'd200);
    chk("hitframe_y1_a", 64'(py_a[19:10]), 64'd196);
    cyc(0, 0, 0, 0, 4'b0, 1);
    chk("rst_act_a", 64'(act_a), 64'd0);
    chk("rst_px_a", 64'(px_a), 64'd0);
    chk("rst_py_a", 64'(py_a), 64'd0);
    chk("rst_live_a", 64'(lc_a), 64'd0);

    // Randomized run
    for (int k = 0; k < 600; k++) begin
      bit          v, f, r;
      logic [3:0]  h;
      v = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      r = ($urandom_range(0, 149) == 0);
      cyc(v, int'($urandom_range(0, 1023)), int'($urandom_range(0, 479)), f, h, r);
    end

    spawn_valid = 1'b0; frame = 1'b0; hit = '0; rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
